// File: rtl/genius_input_checker.sv
// genius_input_checker
// Player-side checker for the Genius game. After a round's sequence has
// been shown, walks the stored sequence one index at a time, waits for one
// clean button press per step and compares it against the expected color.
// Reports exactly one outcome per round: success, mismatch or timeout.

module genius_input_checker #(
  // Cycles allowed per press while waiting before the round times out.
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       check_start,
  input  logic [3:0] round_level,
  input  logic [2:0] buttons,
  input  logic [1:0] seq_value,
  output logic [3:0] seq_index,
  output logic       busy,
  output logic       round_ok,
  output logic       round_fail,
  output logic       fail_timeout
);

  // Last counter value that is still inside the allowed press window.
  localparam logic [31:0] LP_LAST_COUNT = 32'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_level;
  logic [3:0]  r_seq_index;
  logic        r_busy;
  logic        r_round_ok;
  logic        r_round_fail;
  logic        r_fail_timeout;
  logic [31:0] r_count;

  // Button conditioning chain: two synchronizer flops plus the previous
  // synchronized sample used for edge detection.
  logic [2:0]  r_btn_meta;
  logic [2:0]  r_btn_s;
  logic [2:0]  r_btn_p;

  logic        w_press;
  logic        w_one_hot;
  logic [1:0]  w_color;
  logic        w_match;
  logic        w_last_step;
  logic        w_timeout;

  // Synchronize the raw buttons and keep the prior sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_meta <= 3'b000;
      r_btn_s    <= 3'b000;
      r_btn_p    <= 3'b000;
    end else begin
      r_btn_meta <= buttons;
      r_btn_s    <= r_btn_meta;
      r_btn_p    <= r_btn_s;
    end
  end

  // A press only counts when every button was released on the prior cycle,
  // so a held button cannot satisfy more than one step.
  assign w_press = (r_btn_p == 3'b000) && (r_btn_s != 3'b000);

  // Map a single pressed button to its color; anything else is invalid.
  always_comb begin
    w_one_hot = 1'b0;
    w_color   = 2'b00;
    case (r_btn_s)
      3'b001: begin
        w_one_hot = 1'b1;
        w_color   = 2'b00;
      end
      3'b010: begin
        w_one_hot = 1'b1;
        w_color   = 2'b01;
      end
      3'b100: begin
        w_one_hot = 1'b1;
        w_color   = 2'b10;
      end
      default: begin
        w_one_hot = 1'b0;
        w_color   = 2'b00;
      end
    endcase
  end

  // Color 3 is never produced by a button, so a stored 3 can never match.
  assign w_match     = w_one_hot && (seq_value != 2'b11) && (w_color == seq_value);
  assign w_last_step = (r_seq_index == r_level);
  assign w_timeout   = (r_count == LP_LAST_COUNT);

  // Round controller: start latch, fetch bubble, press evaluation, outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_level        <= 4'd0;
      r_seq_index    <= 4'd0;
      r_busy         <= 1'b0;
      r_round_ok     <= 1'b0;
      r_round_fail   <= 1'b0;
      r_fail_timeout <= 1'b0;
      r_count        <= 32'd0;
    end else begin
      // Outcome flags are single-cycle pulses.
      r_round_ok     <= 1'b0;
      r_round_fail   <= 1'b0;
      r_fail_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // seq_index keeps its final value here until the next start.
          if (check_start) begin
            r_level     <= round_level;
            r_seq_index <= 4'd0;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          // One bubble so the sequence source can register the new index.
          r_count <= 32'd0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_count <= r_count + 32'd1;
          // A press in the expiry cycle takes priority over the timeout.
          if (w_press) begin
            if (w_match) begin
              if (w_last_step) begin
                r_round_ok <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= S_IDLE;
              end else begin
                r_seq_index <= r_seq_index + 4'd1;
                r_state     <= S_FETCH;
              end
            end else begin
              r_round_fail <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_round_fail   <= 1'b1;
            r_fail_timeout <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign seq_index    = r_seq_index;
  assign busy         = r_busy;
  assign round_ok     = r_round_ok;
  assign round_fail   = r_round_fail;
  assign fail_timeout = r_fail_timeout;

endmodule

// File: tb/tb_genius_input_checker.sv
// Directed bench for genius_input_checker with a scoreboard of expected
// round outcomes and a registered sequence-source model (2,1,0,1).

module tb_genius_input_checker;

  logic       clk;
  logic       reset;
  logic       check_start;
  logic [3:0] round_level;
  logic [2:0] buttons;
  logic [1:0] seq_value;
  logic [3:0] seq_index;
  logic       busy;
  logic       round_ok;
  logic       round_fail;
  logic       fail_timeout;

  int errors = 0;
  int checks = 0;

  // Expected outcome record: {round_ok, round_fail, fail_timeout, seq_index}
  logic [6:0] exp_q[$];

  genius_input_checker #(.TIMEOUT_CYCLES(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .check_start  (check_start),
    .round_level  (round_level),
    .buttons      (buttons),
    .seq_value    (seq_value),
    .seq_index    (seq_index),
    .busy         (busy),
    .round_ok     (round_ok),
    .round_fail   (round_fail),
    .fail_timeout (fail_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] seq_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    return 2'd2;
      4'd1:    return 2'd1;
      4'd2:    return 2'd0;
      4'd3:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Sequence source: registered lookup, valid one clock after index change.
  always @(posedge clk) seq_value <= seq_lut(seq_index);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every outcome pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (round_ok || round_fail)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_outcome: observed=%b expected=none",
               {round_ok, round_fail, fail_timeout, seq_index});
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check("outcome", {25'd0, round_ok, round_fail, fail_timeout, seq_index}, {25'd0, e});
        $display("outcome ok=%0b fail=%0b timeout=%0b idx=%0d", round_ok, round_fail,
                 fail_timeout, seq_index);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [3:0] lvl);
    round_level = lvl;
    check_start = 1'b1;
    tick();
    check_start = 1'b0;
    round_level = 4'hF;  // must be ignored after the latch
    check("start_busy", 32'(busy), 32'd1);
    check("start_idx", 32'(seq_index), 32'd0);
  endtask

  task automatic press(input logic [2:0] b, input int hold, input int rel);
    buttons = b;
    repeat (hold) tick();
    buttons = 3'b000;
    repeat (rel) tick();
  endtask

  initial begin
    reset       = 1'b1;
    check_start = 1'b0;
    round_level = 4'd0;
    buttons     = 3'b000;
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ok", 32'(round_ok), 32'd0);
    check("rst_fail", 32'(round_fail), 32'd0);
    check("rst_timeout", 32'(fail_timeout), 32'd0);
    check("rst_idx", 32'(seq_index), 32'd0);

    // Full success at level 2
    start_round(4'd2);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd2});
    press(3'b100, 3, 0);
    check("ok_step0_idx", 32'(seq_index), 32'd1);
    press(3'b000, 0, 3);
    press(3'b010, 3, 0);
    check("ok_step1_idx", 32'(seq_index), 32'd2);
    press(3'b000, 0, 3);
    press(3'b001, 3, 0);
    check("ok_pulse", 32'(round_ok), 32'd1);
    check("ok_busy_low", 32'(busy), 32'd0);
    tick();
    check("ok_pulse_end", 32'(round_ok), 32'd0);
    repeat (3) tick();

    // Wrong color at step 1
    start_round(4'd3);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd1});
    press(3'b100, 3, 3);
    press(3'b001, 3, 0);
    check("mis_fail", 32'(round_fail), 32'd1);
    check("mis_timeout", 32'(fail_timeout), 32'd0);
    check("mis_idx", 32'(seq_index), 32'd1);
    check("mis_busy", 32'(busy), 32'd0);
    repeat (3) tick();

    // Timeout with no press: pulse exactly 20 cycles after WAIT_PRESS entry
    start_round(4'd1);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 4'd0});
    repeat (20) tick();
    check("to_not_early", 32'(round_fail), 32'd0);
    check("to_busy_held", 32'(busy), 32'd1);
    tick();
    check("to_fail", 32'(round_fail), 32'd1);
    check("to_flag", 32'(fail_timeout), 32'd1);
    tick();
    check("to_pulse_end", 32'({round_fail, fail_timeout}), 32'd0);
    repeat (2) tick();

    // Multi-button press is invalid
    start_round(4'd1);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0});
    press(3'b110, 3, 0);
    check("inv_fail", 32'(round_fail), 32'd1);
    check("inv_timeout", 32'(fail_timeout), 32'd0);
    press(3'b000, 0, 3);

    // Held button satisfies step 0 only; step 1 times out
    start_round(4'd1);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 4'd1});
    buttons = 3'b100;
    repeat (3) tick();
    check("hold_idx", 32'(seq_index), 32'd1);
    repeat (20) tick();
    check("hold_not_early", 32'(round_fail), 32'd0);
    tick();
    check("hold_fail", 32'(round_fail), 32'd1);
    check("hold_timeout", 32'(fail_timeout), 32'd1);
    buttons = 3'b000;
    repeat (3) tick();

    // Reset in the middle of WAIT_PRESS
    start_round(4'd3);
    press(3'b100, 3, 2);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_idx", 32'(seq_index), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_idx", 32'(seq_index), 32'd0);
    check("arst_pulses", 32'({round_ok, round_fail, fail_timeout}), 32'd0);
    tick();
    reset = 1'b0;
    repeat (25) tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    // Restart at index 0; check_start while busy must not queue a round
    start_round(4'd0);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd0});
    check_start = 1'b1;
    round_level = 4'd5;
    tick();
    check_start = 1'b0;
    press(3'b100, 3, 0);
    check("restart_ok", 32'(round_ok), 32'd1);
    press(3'b000, 0, 3);
    check("no_queued_start", 32'(busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/genius_input_checker.md
# genius_input_checker

Player-side checker for the Genius game. Once the sequence for a round has been shown, this block walks the stored sequence index by index through the sequence source. It waits for one button press per step and compares each press against the expected color. It reports exactly one outcome per round: success, mismatch, or timeout.

## Interface
- TIMEOUT_CYCLES, 50_000_000: cycles allowed per press in WAIT_PRESS before a timeout fail; legal range 2..2^32-1.
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears every register immediately.
- check_start  input  1  level sampled in IDLE; starts a round check.
- round_level  input  4  index of the last step to check; the round covers indices 0..round_level.
- buttons  input  3  raw player buttons, asynchronous; bit0 = color 0, bit1 = color 1, bit2 = color 2.
- seq_value  input  2  expected color from the sequence source; registered there, valid one clk after seq_index changes.
- seq_index  output  4  index driven to the sequence source's sequence_count.
- busy  output  1  high while a check is in progress.
- round_ok  output  1  one-cycle pulse: every step matched.
- round_fail  output  1  one-cycle pulse: wrong color, multi-button press, or timeout.
- fail_timeout  output  1  qualifies round_fail; high in the same cycle when the fail came from a timeout.

## Operation
- Input conditioning:
  - buttons pass through a 2-flop synchronizer, giving btn_s.
  - A third register holds btn_p, the previous btn_s.
  - A press event is btn_p == 3'b000 and btn_s != 3'b000.
  - A new press requires all buttons released first.
- Button-to-color mapping:
  - 3'b001 -> 2'b00, 3'b010 -> 2'b01, 3'b100 -> 2'b10.
  - Any press event with more than one bit set is invalid and fails the round.
- IDLE:
  - busy = 0.
  - If check_start = 1: latch round_level into an internal level register, set seq_index <= 0, set busy <= 1, go to FETCH.
  - round_level changes after the latch are ignored.
- FETCH:
  - Lasts exactly one cycle; lets the sequence source register the new index.
  - Clear the timeout counter and go to WAIT_PRESS.
- WAIT_PRESS: the timeout counter increments every cycle. On each cycle:
  - Press event, color == seq_value, seq_index == level: pulse round_ok, busy <= 0, go to IDLE.
  - Press event, color == seq_value, seq_index < level: seq_index <= seq_index + 1, go to FETCH.
  - Press event, color != seq_value, or invalid press: pulse round_fail, busy <= 0, go to IDLE.
  - No press and counter == TIMEOUT_CYCLES-1: pulse round_fail and fail_timeout, busy <= 0, go to IDLE.
- A seq_value of 2'b11 never matches, so any press at that step fails.
- seq_index holds its last value in IDLE; it is rewritten to 0 at the next start.
- check_start while busy = 1 is ignored. It is not queued.
- No outcome is reported without a press or a timeout. Exactly one of round_ok or round_fail pulses per round.

## Timing
- Reset values: seq_index = 0, busy = 0, round_ok = 0, round_fail = 0, fail_timeout = 0, state = IDLE, synchronizer and btn_p = 0, counter = 0.
- Start: check_start is seen at edge E0. busy and seq_index = 0 are visible after E0. FETCH spans E0..E1, WAIT_PRESS begins after E1, and seq_value for index 0 is valid from E1.
- Button latency: a raw button rising before edge N produces the press event in the cycle after edge N+1. The decision is registered at edge N+2.
- Outcome: round_ok/round_fail go high for exactly the one cycle after the deciding edge. busy falls on that same edge.
- Per-step overhead: 1 FETCH cycle plus the press wait.
- Simultaneous events: a press event on the same cycle as timeout expiry wins; the press is evaluated and no timeout is reported.
- Reset mid-round: outputs drop immediately and asynchronously. No pulse is emitted, and the next round needs a new check_start.
- round_level = 0: a single press decides the round.
- round_level = 15: seq_index reaches 15 and never wraps; success is reported at index 15.

## Test plan
Bench models the sequence source as a registered lookup returning 2,1,0,1 for indices 0..3. TIMEOUT_CYCLES = 20.
- Reset, then idle 10 cycles -> all outputs 0, seq_index = 0.
- round_level = 2; presses 3'b100, 3'b010, 3'b001, each held 3 cycles with 3-cycle release -> seq_index steps 0,1,2; one round_ok pulse; round_fail never asserted; busy falls with the pulse.
- round_level = 3; presses 3'b100, then 3'b001 -> round_fail pulse, fail_timeout = 0, seq_index = 1, busy = 0.
- round_level = 1; no press after start -> round_fail and fail_timeout high together exactly 20 cycles after WAIT_PRESS entry.
- round_level = 1; press 3'b110 -> round_fail. Separately, hold 3'b100 without release across both steps -> the second step sees no new press and times out.
- Assert reset mid-WAIT_PRESS -> immediate return to reset values with no pulse. A later check_start restarts at seq_index = 0; check_start pulsed while busy changes nothing.
